aes_sbox_arbiter: RTL



---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sbox_word.sv | 24 ++
 rtl/aes_sbox_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared lane constants, FSM/grant enums and GF(2^8) multiply for the S-box arbiter.
package aes_pkg;
  localparam int SBOX_LANES = 4;
  localparam int ST_BEATS = 4;
  localparam int LANE_W = 8 * SBOX_LANES;
  localparam int BEAT_W = $clog2(ST_BEATS);
  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_e;
  typedef enum logic {GR_ST, GR_KW} grant_e;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: combinational 32-bit lane of four forward AES S-boxes.
// Inversion uses the x^254 squaring chain over GF(2^8), followed by the AES affine map.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin sharing of one S-box lane between SubBytes (4 beats) and SubWord.
// Define AES_SBOX_KW_PREEMPT_EN to let key words interleave into a running state.
module aes_sbox_arbiter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_res_valid,
  output logic [127:0] st_res_data,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_data,
  output logic         kw_res_valid,
  output logic [31:0]  kw_res_data,
  output logic         busy
);
  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [127:0]       st_buf_q, st_buf_d, st_res_data_q, st_res_data_d;
  logic [LANE_W-1:0]  kw_buf_q, kw_buf_d, kw_res_data_q, kw_res_data_d;
  logic               st_res_valid_q, st_res_valid_d, kw_res_valid_q, kw_res_valid_d;
  logic               kw_slot_q, kw_slot_d;
  logic               idle, st_win, kw_pre, lane_kw;
  logic [LANE_W-1:0]  lane_in, lane_out;
  assign idle = state_q == IDLE;
  assign st_win = st_valid && (!kw_valid || last_grant_q == GR_KW);
`ifdef AES_SBOX_KW_PREEMPT_EN
  assign kw_pre = state_q == ST_RUN && !kw_slot_q && beat_q < BEAT_W'(ST_BEATS - 1);
`else
  assign kw_pre = 1'b0;
`endif
  assign st_ready = rst_n && idle && st_win;
  assign kw_ready = rst_n && ((idle && !st_win) || kw_pre);
  assign lane_kw = state_q == KW_RUN || kw_slot_q;
  assign lane_in = lane_kw ? kw_buf_q : st_buf_q[LANE_W*beat_q +: LANE_W];
  aes_sbox_word u_sbox (.din(lane_in), .dout(lane_out));
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    beat_d = beat_q;
    st_buf_d = st_buf_q;
    kw_buf_d = kw_buf_q;
    st_res_data_d = st_res_data_q;
    kw_res_data_d = kw_res_data_q;
    st_res_valid_d = 1'b0;
    kw_res_valid_d = 1'b0;
    kw_slot_d = 1'b0;
    if (st_valid && st_ready) begin
      st_buf_d = st_data;
      beat_d = '0;
      state_d = ST_RUN;
    end
    if (kw_valid && kw_ready) begin
      kw_buf_d = kw_data;
      state_d = idle ? KW_RUN : state_d;
      kw_slot_d = !idle;
    end
    if (lane_kw) begin
      kw_res_data_d = lane_out;
      kw_res_valid_d = 1'b1;
    end
    if (state_q == KW_RUN) begin
      state_d = IDLE;
      last_grant_d = GR_KW;
    end else if (state_q == ST_RUN && !kw_slot_q) begin
      st_res_data_d[LANE_W*beat_q +: LANE_W] = lane_out;
      beat_d = beat_q + 1'b1;
      if (beat_q == BEAT_W'(ST_BEATS - 1)) begin
        state_d = IDLE;
        st_res_valid_d = 1'b1;
        last_grant_d = GR_ST;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_grant_q <= GR_KW;
      beat_q <= '0;
      st_buf_q <= '0;
      kw_buf_q <= '0;
      st_res_data_q <= '0;
      kw_res_data_q <= '0;
      st_res_valid_q <= 1'b0;
      kw_res_valid_q <= 1'b0;
      kw_slot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      beat_q <= beat_d;
      st_buf_q <= st_buf_d;
      kw_buf_q <= kw_buf_d;
      st_res_data_q <= st_res_data_d;
      kw_res_data_q <= kw_res_data_d;
      st_res_valid_q <= st_res_valid_d;
      kw_res_valid_q <= kw_res_valid_d;
      kw_slot_q <= kw_slot_d;
    end
  end
  assign st_res_valid = st_res_valid_q;
  assign st_res_data = st_res_data_q;
  assign kw_res_valid = kw_res_valid_q;
  assign kw_res_data = kw_res_data_q;
  assign busy = !idle;
endmodule
